// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and the
// wrap-around adder that all requesters share.
package adder_arbiter_pkg;

  localparam int ADDER_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // The shared adder: carry-out is discarded, so the sum wraps modulo 256.
  function automatic logic [ADDER_W-1:0] adder_add(
    input logic [ADDER_W-1:0] operand0,
    input logic [ADDER_W-1:0] operand1
  );
    logic [ADDER_W-1:0] result;
    result = operand0 + operand1;
    return result;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin priority encoder. Searches the request vector
// starting one position after last_i, wrapping at N, and returns the first
// set bit as a one-hot grant and as a binary index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Walk the candidates last+1, last+2, ... (mod N) and keep the first hit.
  always_comb begin
    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand;
    logic          found;
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, last_i} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N)) begin
        cand_sum = cand_sum - (IW+1)'(N);
      end else begin
        cand_sum = cand_sum;
      end
      cand = cand_sum[IW-1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end else begin
        found = found;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 8-bit wrap-around adder between NUM_REQ requesters. A
// round-robin winner is accepted in IDLE, its operands are summed from
// registers in CALC, and the tagged sum is offered in RESP until consumed.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op0,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op0_q, op0_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic                resp_valid_q, resp_valid_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ready_s;

  logic [NUM_REQ-1:0]  win_gnt_s;
  logic [ID_W-1:0]     win_idx_s;
  logic                any_req_s;
  logic [DATA_W-1:0]   sum_s;

  logic [DATA_W-1:0]   op0_arr_s [NUM_REQ];
  logic [DATA_W-1:0]   op1_arr_s [NUM_REQ];

  // Unpack the flat operand buses into per-requester slices.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op0_arr_s[i] = req_op0[i*DATA_W +: DATA_W];
    assign op1_arr_s[i] = req_op1[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (win_gnt_s),
    .idx_o  (win_idx_s),
    .any_o  (any_req_s)
  );

  // The single shared adder, always fed from the operand registers.
  always_comb begin
    sum_s = adder_add(op0_q, op1_q);
  end

  // Next-state, handshake and datapath-load decisions for the three-phase FSM.
  always_comb begin
    state_d      = state_q;
    op0_d        = op0_q;
    op1_d        = op1_q;
    id_d         = id_q;
    last_d       = last_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    ready_s      = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          ready_s = win_gnt_s;
          op0_d   = op0_arr_s[win_idx_s];
          op1_d   = op1_arr_s[win_idx_s];
          id_d    = win_idx_s;
          last_d  = win_idx_s;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        resp_data_d  = sum_s;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op0_q        <= {DATA_W{1'b0}};
      op1_q        <= {DATA_W{1'b0}};
      id_q         <= {ID_W{1'b0}};
      last_q       <= ID_W'(NUM_REQ - 1);
      resp_data_q  <= {DATA_W{1'b0}};
      resp_id_q    <= {ID_W{1'b0}};
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op0_q        <= op0_d;
      op1_q        <= op1_d;
      id_q         <= id_d;
      last_q       <= last_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op0;
  logic [NUM_REQ*DATA_W-1:0] req_op1;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_data;
  logic [ID_W-1:0]           resp_id;
  logic                      busy;

  adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one operation in flight at most.
  bit m_busy;
  int m_age;
  int m_last;
  int m_exp_data;
  int m_exp_id;
  int cyc;
  int last_accept_cyc;
  int accept_gap;

  // Observations from the most recent tick.
  bit             acc;
  bit             hs;
  int             hs_data;
  int             hs_id;
  logic [NUM_REQ-1:0] obs_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Round-robin choice straight from the rule: first valid after last, wrapping.
  function automatic int rr_choice(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    bit exp_rv;
    #1;
    acc = 1'b0;
    hs  = 1'b0;
    obs_ready = req_ready;
    if (rst === 1'b0) begin
      g = m_busy ? -1 : rr_choice(req_valid, m_last);
      exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      exp_rv = m_busy && (m_age >= 1);
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check_eq("resp_data", 32'(resp_data), 32'(m_exp_data));
        check_eq("resp_id", 32'(resp_id), 32'(m_exp_id));
      end
      if (g >= 0) begin
        m_busy     = 1'b1;
        m_age      = 0;
        m_last     = g;
        m_exp_data = (int'(req_op0[g*DATA_W +: DATA_W]) + int'(req_op1[g*DATA_W +: DATA_W])) % 256;
        m_exp_id   = g;
        accept_gap = cyc - last_accept_cyc;
        last_accept_cyc = cyc;
        acc = 1'b1;
      end else if (m_busy) begin
        if (m_age >= 1 && resp_ready) begin
          m_busy  = 1'b0;
          hs      = 1'b1;
          hs_data = int'(resp_data);
          hs_id   = int'(resp_id);
        end else begin
          m_age++;
        end
      end
    end
    @(posedge clk);
    if (rst === 1'b1) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = NUM_REQ - 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_hs(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (hs) return;
    end
    check_eq("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b);
    req_op0[r*DATA_W +: DATA_W] = a;
    req_op1[r*DATA_W +: DATA_W] = b;
  endtask

  initial begin
    int n_acc;
    int n_hs;
    logic [7:0] held_data;
    logic [1:0] held_id;

    rst = 1'b1; req_valid = '0; req_op0 = '0; req_op1 = '0; resp_ready = 1'b0;
    m_busy = 1'b0; m_age = 0; m_last = NUM_REQ - 1; cyc = 0; last_accept_cyc = -100;
    @(negedge clk);

    // Reset for two cycles, then confirm the idle state.
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_resp_data", 32'(resp_data), 32'h00);
    check_eq("rst_resp_id", 32'(resp_id), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    tick();

    // Single requester 0x12 + 0x34.
    resp_ready = 1'b1;
    req_valid = 4'b0001; set_ops(0, 8'h12, 8'h34);
    tick();
    check_eq("single_ready", 32'(obs_ready), 32'h1);
    req_valid = 4'b0000;
    wait_hs(10);
    check_eq("single_data", 32'(hs_data), 32'h46);
    check_eq("single_id", 32'(hs_id), 32'h0);
    tick();

    // Wrap-around sums.
    req_valid = 4'b0100; set_ops(2, 8'hFF, 8'h01);
    tick();
    req_valid = 4'b0000;
    wait_hs(10);
    check_eq("wrap_ff_data", 32'(hs_data), 32'h00);
    check_eq("wrap_ff_id", 32'(hs_id), 32'h2);
    req_valid = 4'b1000; set_ops(3, 8'h80, 8'h80);
    tick();
    req_valid = 4'b0000;
    wait_hs(10);
    check_eq("wrap_80_data", 32'(hs_data), 32'h00);
    check_eq("wrap_80_id", 32'(hs_id), 32'h3);
    tick();

    // Fairness: all requesters held valid, eight operations.
    for (int r = 0; r < NUM_REQ; r++) set_ops(r, 8'($urandom), 8'($urandom));
    req_valid = 4'b1111;
    n_acc = 0; n_hs = 0;
    for (int i = 0; i < 60 && n_hs < 8; i++) begin
      tick();
      if (acc) begin
        check_eq("fair_grant", 32'(obs_ready), 32'(4'b0001 << (n_acc % NUM_REQ)));
        if (n_acc > 0) check_eq("fair_gap", 32'(accept_gap), 32'd3);
        n_acc++;
      end
      if (hs) begin
        check_eq("fair_id", 32'(hs_id), 32'(n_hs % NUM_REQ));
        n_hs++;
      end
    end
    check_eq("fair_count", 32'(n_hs), 32'd8);
    req_valid = 4'b0000;
    tick();

    // Backpressure: hold the response for five cycles.
    resp_ready = 1'b0;
    req_valid = 4'b0010; set_ops(1, 8'h5A, 8'h21);
    tick();
    req_valid = 4'b0011; set_ops(0, 8'h01, 8'h02);
    for (int i = 0; i < 5 && resp_valid !== 1'b1; i++) tick();
    held_data = resp_data; held_id = resp_id;
    check_eq("bp_first", 32'(held_data), 32'h7B);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_data", 32'(resp_data), 32'(held_data));
      check_eq("bp_id", 32'(resp_id), 32'(held_id));
      check_eq("bp_busy", 32'(busy), 32'h1);
      check_eq("bp_ready", 32'(obs_ready), 32'h0);
    end
    resp_ready = 1'b1;
    tick();
    check_eq("bp_hs", 32'(hs), 32'h1);
    tick();
    check_eq("bp_next", 32'(obs_ready), 32'h1);
    req_valid = 4'b0000;
    wait_hs(10);
    tick();

    // Reset in the middle of an operation.
    req_valid = 4'b0100; set_ops(2, 8'h11, 8'h22);
    tick();
    req_valid = 4'b1110;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(resp_valid), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    req_valid = 4'b1111;
    tick();
    check_eq("mid_rst_grant", 32'(obs_ready), 32'h1);
    req_valid = 4'b0000;
    wait_hs(10);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ($urandom_range(0, 3) == 0) req_valid[r] = 1'($urandom);
      end
      req_op0    = {$urandom};
      req_op1    = {$urandom};
      resp_ready = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
